// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage with ready/ack data bus; optional MEM_ALIGN_CHECK_EN alignment trap
package mem_access_pkg;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic        mem_write;
        logic        mem_read;
        logic        reg_write;
        logic [4:0]  rd;
    } ex_to_mem_s;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_to_wb_s;

endpackage

module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  ex_to_mem_s  ex_to_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output mem_to_wb_s  mem_to_wb,
    output logic [31:0] bp_mem,
    output logic        stall_mem,
    output logic        bus_err,
    output logic        align_err
);

    localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic          cap_we;

    logic          access;
    logic          misalign;
    logic          issue;
    logic          req_c;
    logic          we_c;
    logic          stall_c;
    logic          complete;
    logic          timeout;
    logic [31:0]   addr_c;
    logic [31:0]   wdata_c;

    assign access = ex_to_mem.mem_read | ex_to_mem.mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    // A misaligned access is trapped before it reaches the bus; only meaningful while idle
    assign misalign = access && (state == IDLE) && (ex_to_mem.alu_result[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign issue = access & ~misalign;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: enter WAIT on an unacknowledged request, leave on ack or timeout
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (issue && !dmem_ack) state_nx = WAIT;
            WAIT: if (dmem_ack || (wait_cnt == CNT_LAST)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: bus drive from ex_to_mem while idle, from captured copy while waiting
    always_comb begin
        req_c    = 1'b0;
        we_c     = 1'b0;
        addr_c   = {ex_to_mem.alu_result[31:2], 2'b00};
        wdata_c  = ex_to_mem.write_data;
        stall_c  = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    req_c = 1'b1;
                    we_c  = ex_to_mem.mem_write;
                    if (dmem_ack) complete = 1'b1;
                    else          stall_c  = 1'b1;
                end
            end
            WAIT: begin
                req_c   = 1'b1;
                we_c    = cap_we;
                addr_c  = cap_addr;
                wdata_c = cap_wdata;
                if (dmem_ack)                    complete = 1'b1;
                else if (wait_cnt == CNT_LAST)   timeout  = 1'b1;
                else                             stall_c  = 1'b1;
            end
            default: ;
        endcase
    end

    assign dmem_req   = req_c & ~rst;
    assign dmem_we    = we_c & ~rst;
    assign stall_mem  = stall_c & ~rst;
    assign dmem_addr  = addr_c;
    assign dmem_wdata = wdata_c;
    assign bp_mem     = ex_to_mem.alu_result;

    // Wait counter and request capture; counter starts at 1 because the first cycle already elapsed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_we    <= 1'b0;
        end else if (state == IDLE) begin
            if (stall_c) begin
                wait_cnt  <= CW'(1);
                cap_addr  <= {ex_to_mem.alu_result[31:2], 2'b00};
                cap_wdata <= ex_to_mem.write_data;
                cap_we    <= ex_to_mem.mem_write;
            end
        end else if (stall_c) begin
            if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Writeback register: bubble while stalled, on timeout or on a trapped access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_to_wb <= '0;
        end else if (stall_c || timeout || misalign) begin
            mem_to_wb <= '0;
        end else begin
            mem_to_wb.result    <= (complete && !ex_to_mem.mem_write) ? dmem_rdata
                                                                      : ex_to_mem.alu_result;
            mem_to_wb.rd        <= ex_to_mem.rd;
            mem_to_wb.reg_write <= ex_to_mem.reg_write;
        end
    end

    // Sticky bus error on timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if (timeout) begin
            bus_err <= 1'b1;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Sticky alignment error on a trapped access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_err <= 1'b0;
        end else if (misalign) begin
            align_err <= 1'b1;
        end
    end
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized scoreboard bench for mem_access
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    ex_to_mem_s  ex_to_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    mem_to_wb_s  mem_to_wb;
    logic [31:0] bp_mem;
    logic        stall_mem;
    logic        bus_err;
    logic        align_err;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_to_mem  (ex_to_mem),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .mem_to_wb  (mem_to_wb),
        .bp_mem     (bp_mem),
        .stall_mem  (stall_mem),
        .bus_err    (bus_err),
        .align_err  (align_err)
    );

    typedef struct {
        mem_to_wb_s wb;
        logic       berr;
        logic       aerr;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       compared   = 0;
    int       mismatched = 0;
    logic     exp_berr   = 1'b0;
    logic     exp_aerr   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One instruction: d is the cycle in which ack arrives (>= T means never)
    task automatic run_instr(input ex_to_mem_s e, input int d, input logic [31:0] ack_data);
        bit       acc;
        bit       mis;
        bit       issue;
        int       n;
        sb_item_t it;
        acc = e.mem_read || e.mem_write;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = acc && (e.alu_result[1:0] != 2'b00);
`endif
        issue = acc && !mis;
        n = !issue ? 0 : ((d < T) ? d : T - 1);
        it.wb = '0;
        if (!acc) begin
            it.wb.result    = e.alu_result;
            it.wb.rd        = e.rd;
            it.wb.reg_write = e.reg_write;
        end else if (issue && d < T) begin
            it.wb.result    = e.mem_write ? e.alu_result : ack_data;
            it.wb.rd        = e.rd;
            it.wb.reg_write = e.reg_write;
        end
        if (issue && d >= T) exp_berr = 1'b1;
        if (mis) exp_aerr = 1'b1;
        it.berr = exp_berr;
        it.aerr = exp_aerr;
        sb_q.push_back(it);
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            #1;
            rst        = 1'b0;
            ex_to_mem  = e;
            dmem_ack   = issue ? (k == d) : 1'($urandom_range(0, 1));
            dmem_rdata = (issue && k == d) ? ack_data : $urandom;
            #2;
            chk("stall", stall_mem, 64'(k < n));
            chk("req", dmem_req, 64'(issue));
            chk("bp_mem", bp_mem, e.alu_result);
            if (issue) begin
                chk("addr", dmem_addr, {e.alu_result[31:2], 2'b00});
                chk("we", dmem_we, e.mem_write);
                if (e.mem_write) chk("wdata", dmem_wdata, e.write_data);
            end
        end
    endtask

    // Monitor: a non-stalled cycle retires one instruction at its closing edge
    initial begin
        logic     s;
        logic     r;
        sb_item_t it;
        forever begin
            @(negedge clk);
            #4;
            s = stall_mem;
            r = rst;
            @(posedge clk);
            #1;
            if (!r) begin
                if (s) begin
                    chk("bubble", mem_to_wb, 64'd0);
                end else if (sb_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sb_empty: writeback with no expected entry, got %0h", mem_to_wb);
                end else begin
                    it = sb_q.pop_front();
                    chk("wb", mem_to_wb, it.wb);
                    chk("bus_err", bus_err, it.berr);
                    chk("align_err", align_err, it.aerr);
                end
            end
        end
    end

    initial begin
        ex_to_mem_s e;
        ex_to_mem  = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        #3;
        chk("rst_wb", mem_to_wb, 64'd0);
        chk("rst_bus_err", bus_err, 64'd0);
        chk("rst_align_err", align_err, 64'd0);
        chk("rst_stall", stall_mem, 64'd0);
        chk("rst_req", dmem_req, 64'd0);
        chk("rst_we", dmem_we, 64'd0);

        e = '0; e.alu_result = 32'h1234; e.rd = 5'd5; e.reg_write = 1'b1;
        run_instr(e, 0, 32'h0);
        e = '0; e.alu_result = 32'h100; e.mem_read = 1'b1; e.rd = 5'd3; e.reg_write = 1'b1;
        run_instr(e, 0, 32'hDEADBEEF);
        e = '0; e.alu_result = 32'h200; e.write_data = 32'hA5A5A5A5; e.mem_write = 1'b1; e.rd = 5'd9;
        run_instr(e, 3, 32'h0);
        e = '0; e.alu_result = 32'h204; e.mem_read = 1'b1; e.rd = 5'd12; e.reg_write = 1'b1;
        run_instr(e, T - 1, 32'hCAFEF00D);
        e = '0; e.alu_result = 32'h208; e.mem_read = 1'b1; e.rd = 5'd13; e.reg_write = 1'b1;
        run_instr(e, 99, 32'h0);

        e = '0; e.alu_result = 32'h300; e.mem_read = 1'b1; e.rd = 5'd7; e.reg_write = 1'b1;
        @(negedge clk);
        #1;
        ex_to_mem = e;
        dmem_ack  = 1'b0;
        #2;
        chk("wait_stall", stall_mem, 64'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("rst_mid_req", dmem_req, 64'd0);
        chk("rst_mid_stall", stall_mem, 64'd0);
        chk("rst_mid_wb", mem_to_wb, 64'd0);
        chk("rst_mid_bus_err", bus_err, 64'd0);
        exp_berr = 1'b0;
        exp_aerr = 1'b0;

        e = '0; e.alu_result = 32'h104; e.mem_read = 1'b1; e.rd = 5'd8; e.reg_write = 1'b1;
        run_instr(e, 1, 32'h5A5A0001);
        e = '0; e.alu_result = 32'h102; e.mem_read = 1'b1; e.rd = 5'd4; e.reg_write = 1'b1;
        run_instr(e, 0, 32'h11223344);

        for (int i = 0; i < 300; i++) begin
            e.alu_result = $urandom;
            if ($urandom_range(0, 3) != 0) e.alu_result[1:0] = 2'b00;
            e.write_data = $urandom;
            e.mem_read   = 1'($urandom_range(0, 1));
            e.mem_write  = ($urandom_range(0, 2) == 0);
            e.reg_write  = 1'($urandom_range(0, 1));
            e.rd         = 5'($urandom_range(0, 31));
            run_instr(e, $urandom_range(0, T + 1), $urandom);
        end

        @(posedge clk);
        #3;
        chk("sb_drain", sb_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage between `execute` and writeback. Consumes the `ex_to_mem_s` register that `execute` produces and performs word loads and stores over a ready/ack data-bus handshake. It stalls the front of the pipeline while a bus access is outstanding, aborts on timeout, and produces the registered `mem_to_wb` bundle plus the `bp_mem` bypass value fed back to `execute`.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles an access may wait for `dmem_ack`, counting its first cycle. Legal range is 2..255.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `ex_to_mem` in `ex_to_mem_s`: uses `alu_result`, `write_data`, `mem_write`, `mem_read`, `reg_write`, `rd`. Upstream holds it stable while `stall_mem` is high.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out 32: word address, byte-addressed, bits [1:0] always 00.
- `dmem_wdata` out 32: store data.
- `dmem_ack` in 1: access complete this cycle. Ignored when `dmem_req` is 0.
- `dmem_rdata` in 32: load data, valid when `dmem_ack` is high.
- `mem_to_wb` out struct: registered `{result[31:0], rd[4:0], reg_write}`.
- `bp_mem` out 32: combinational copy of `ex_to_mem.alu_result`, used as the bypass value by `execute`.
- `stall_mem` out 1: freeze fetch, decode and execute this cycle.
- `bus_err` out 1: sticky flag, set on timeout.
- `align_err` out 1: sticky flag, set on a misaligned access. Only driven when `MEM_ALIGN_CHECK_EN` is defined.

## Operation
- An access is present when `mem_read | mem_write`. If both are set, the store wins; `result` is then `alu_result`.
- The FSM has two states, IDLE and WAIT.
- IDLE, no access present:
  - The bus is idle and `stall_mem` = 0.
  - At the clock edge, `mem_to_wb` loads `{alu_result, rd, reg_write}`.
- IDLE, access present:
  - `dmem_req` = 1 combinationally.
  - Address, data and write-enable are taken from `ex_to_mem`.
  - If `dmem_ack` = 1: the access completes this cycle with no stall.
  - If `dmem_ack` = 0: `stall_mem` = 1, the request is captured into internal registers, the wait counter is set to 1, and the FSM moves to WAIT.
- WAIT:
  - The bus is driven from the captured registers and `dmem_req` stays high.
  - If `dmem_ack` = 1: the access completes and the FSM returns to IDLE.
  - Otherwise, if the counter equals `TIMEOUT_CYCLES`-1: timeout (see below).
  - Otherwise: the counter increments and `stall_mem` stays 1.
- On completion:
  - `stall_mem` = 0 in that cycle.
  - For a load, `mem_to_wb.result` is `dmem_rdata`. For a store, it is `alu_result`.
  - `mem_to_wb.reg_write` is `ex_to_mem.reg_write`.
- On timeout:
  - `stall_mem` = 0 in the timeout cycle.
  - `mem_to_wb` receives a bubble (`reg_write` = 0).
  - `bus_err` is set and the FSM returns to IDLE.
  - If `dmem_ack` arrives in the timeout cycle, the ack wins.
- While `stall_mem` = 1, `mem_to_wb` loads a bubble (`reg_write` = 0, `rd` = 0, `result` = 0) at each edge.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`. The counter saturates and never wraps.

## Timing
- Reset values, and the values forced while `rst` is high:
  - State is IDLE and the counter is 0.
  - `mem_to_wb` is all-zero.
  - `bus_err` = 0 and `align_err` = 0.
  - `dmem_req`, `dmem_we` and `stall_mem` are forced to 0.
- Non-memory instruction: one cycle. `mem_to_wb` is valid after the edge that ends the cycle it was presented.
- Access first presented in cycle 0 with `dmem_ack` first seen in cycle n (n < `TIMEOUT_CYCLES`):
  - `stall_mem` is high in cycles 0..n-1.
  - `mem_to_wb` updates at the end of cycle n.
- No ack by cycle `TIMEOUT_CYCLES`-1: the abort takes effect at the end of that cycle.
- Reset asserted during WAIT: the request is dropped, nothing is written back, and the FSM is in IDLE on the next cycle.
- `bp_mem` has zero latency and does not depend on state.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - An access with `alu_result[1:0]` != 00 issues no bus request and does not stall.
  - It completes in one cycle with `reg_write` = 0, and `align_err` is set (sticky).
- `MEM_ALIGN_CHECK_EN` undefined:
  - `alu_result[1:0]` is ignored; `dmem_addr` is `{alu_result[31:2], 2'b00}`.
  - `align_err` is tied to 0.

## Test plan
- ALU op: `alu_result` = 0x1234, `rd` = 5, `reg_write` = 1 → next cycle `mem_to_wb` = {0x1234, 5, 1}, no `dmem_req`, `stall_mem` stays 0.
- Zero-wait load: addr 0x100, `dmem_ack` in cycle 0, `rdata` = 0xDEADBEEF, `rd` = 3 → `mem_to_wb.result` = 0xDEADBEEF with no stall cycle.
- Three-wait store: addr 0x200, data 0xA5A5A5A5, ack in cycle 3 → `stall_mem` high in cycles 0–2, `dmem_we` = 1, bus stable throughout, `mem_to_wb.reg_write` = 0.
- Timeout with `TIMEOUT_CYCLES` = 4 and no ack → stall in cycles 0–2, bubble written back, `bus_err` = 1 from cycle 4 onward. A second variant with ack in cycle 3 completes normally with `bus_err` = 0.
- `rst` pulsed in cycle 1 of a waiting load → `dmem_req` = 0 immediately, `mem_to_wb` is zero, the next access proceeds normally.
- With `MEM_ALIGN_CHECK_EN`, load at 0x102 → no request, `align_err` = 1, `reg_write` = 0. Without the macro, the same load shows `dmem_addr` = 0x100.
